// File: rtl/decryptor_if.sv
// rtl/decryptor_if.sv - decryptor request/response bundle; resync only with DECRYPTOR_RESYNC_EN
interface decryptor_if;
  logic       decrypt_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       dy_status;
  logic       busy;
`ifdef DECRYPTOR_RESYNC_EN
  logic       resync;

  modport master (output decrypt_enable, data_in, resync, input data_out, dy_status, busy);
  modport slave  (input decrypt_enable, data_in, resync, output data_out, dy_status, busy);
`else
  modport master (output decrypt_enable, data_in, input data_out, dy_status, busy);
  modport slave  (input decrypt_enable, data_in, output data_out, dy_status, busy);
`endif
endinterface

// File: rtl/decryptor.sv
// rtl/decryptor.sv - LFSR-keyed, two-block-chained byte decryptor; DECRYPTOR_RESYNC_EN adds key/chain resync
module decryptor (
  input  logic        clk,
  input  logic        rst_n,
  decryptor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LFSR = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] KEY_SEED   = 8'hBB;
  localparam logic [7:0] CHAIN_SEED = 8'hAE;

  state_t     state;
  logic [7:0] key_reg;
  logic [7:0] chain_reg;
  logic [7:0] last_reg;
  logic [7:0] c_reg;
  logic [7:0] data_out_r;
  logic       dy_r;
  logic       busy_r;
  logic       resync_req;

`ifdef DECRYPTOR_RESYNC_EN
  assign resync_req = bus.resync;
`else
  assign resync_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_reg    <= KEY_SEED;
      chain_reg  <= CHAIN_SEED;
      last_reg   <= 8'h00;
      c_reg      <= 8'h00;
      data_out_r <= 8'h00;
      dy_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // resync wins over a simultaneous start request
          if (resync_req) begin
            key_reg   <= KEY_SEED;
            chain_reg <= CHAIN_SEED;
            last_reg  <= 8'h00;
          end else if (bus.decrypt_enable) begin
            c_reg  <= bus.data_in;
            state  <= LFSR;
            busy_r <= 1'b1;
          end
        end
        LFSR: begin
          key_reg <= {key_reg[6:0], key_reg[7] ^ key_reg[5] ^ key_reg[4] ^ key_reg[3]};
          state   <= DEC;
        end
        DEC: begin
          // chain lags two blocks to mirror the encryptor's prev_output pipeline
          data_out_r <= c_reg ^ key_reg ^ chain_reg;
          chain_reg  <= last_reg;
          last_reg   <= c_reg;
          dy_r       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          dy_r   <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          dy_r   <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.dy_status = dy_r;
  assign bus.busy      = busy_r;

endmodule
